// File: rtl/dds_poly_eval.sv
// Polynomial DDS evaluator: splits phase into segment/fraction, addresses the coefficient ROMs and
// evaluates A0 + x*(A1 + x*A2) over a 3-stage stall-able pipeline. Build macro: DDS_POLY_ROUND_EN.
module dds_poly_eval #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PHASE_WIDTH-1:0] phase,
  output logic                   rom_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  coef_a0,
  input  logic [DATA_WIDTH-1:0]  coef_a1,
  input  logic [DATA_WIDTH-1:0]  coef_a2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data
);

  localparam int FRAC_WIDTH = PHASE_WIDTH - ADDR_WIDTH;
  localparam int P1W        = DATA_WIDTH + FRAC_WIDTH + 1;
  localparam int TW         = DATA_WIDTH + 1;
  localparam int P2W        = TW + FRAC_WIDTH + 1;
  localparam int SW         = DATA_WIDTH + 2;

`ifdef DDS_POLY_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic signed [P1W-1:0] RND1 = ROUND_EN ? (P1W'(1) << (FRAC_WIDTH - 1)) : '0;
  localparam logic signed [P2W-1:0] RND2 = ROUND_EN ? (P2W'(1) << (FRAC_WIDTH - 1)) : '0;
  localparam logic signed [SW-1:0]  SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]  SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic                          advance;
  logic                          v0_reg, v1_reg, v2_reg;
  logic [FRAC_WIDTH-1:0]         x0_reg, x1_reg;
  logic signed [TW-1:0]          t_reg, t_next;
  logic signed [DATA_WIDTH-1:0]  a0_d_reg;
  logic [DATA_WIDTH-1:0]         out_data_reg, out_data_next;
  logic signed [P1W-1:0]         p1, p1_sh;
  logic signed [P2W-1:0]         p2, p2_sh;
  logic signed [SW-1:0]          sum;
  logic                          unused_hi;

  // One advance signal freezes every stage and the ROM output register together.
  assign advance   = !v2_reg || out_ready;
  assign in_ready  = advance;
  assign rom_en    = advance;
  assign rom_addr  = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign out_valid = v2_reg;
  assign out_data  = out_data_reg;

  always_comb begin
    p1     = P1W'($signed(coef_a2)) * P1W'($signed({1'b0, x0_reg}));
    p1_sh  = (p1 + RND1) >>> FRAC_WIDTH;
    t_next = TW'($signed(coef_a1)) + TW'(p1_sh);
    p2     = P2W'(t_reg) * P2W'($signed({1'b0, x1_reg}));
    p2_sh  = (p2 + RND2) >>> FRAC_WIDTH;
    sum    = SW'(a0_d_reg) + SW'(p2_sh);
    if (sum > SAT_MAX) begin
      out_data_next = DATA_WIDTH'(SAT_MAX);
    end else if (sum < SAT_MIN) begin
      out_data_next = DATA_WIDTH'(SAT_MIN);
    end else begin
      out_data_next = DATA_WIDTH'(sum);
    end
  end

  // Shifted products carry only sign bits above the kept width.
  assign unused_hi = ^{p1_sh[P1W-1:TW], p2_sh[P2W-1:SW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_reg       <= 1'b0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      x0_reg       <= '0;
      x1_reg       <= '0;
      t_reg        <= '0;
      a0_d_reg     <= '0;
      out_data_reg <= '0;
    end else if (advance) begin
      v0_reg       <= in_valid;
      x0_reg       <= phase[FRAC_WIDTH-1:0];
      v1_reg       <= v0_reg;
      t_reg        <= t_next;
      a0_d_reg     <= $signed(coef_a0);
      x1_reg       <= x0_reg;
      v2_reg       <= v1_reg;
      out_data_reg <= out_data_next;
    end
  end

endmodule
